// File: rtl/exponent_axi_pkg.sv
// Register map, response codes and sequencer state encoding shared
// by the exponent AXI4-Lite master and its transaction engine.
package exponent_axi_pkg;

  localparam logic [31:0] OFS_X     = 32'h00;
  localparam logic [31:0] OFS_A     = 32'h04;
  localparam logic [31:0] OFS_START = 32'h08;
  localparam logic [31:0] OFS_P     = 32'h0C;
  localparam logic [31:0] OFS_DONE  = 32'h10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_X    = 3'd1;
  localparam logic [2:0] S_WR_A    = 3'd2;
  localparam logic [2:0] S_WR_GO   = 3'd3;
  localparam logic [2:0] S_RD_DONE = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;
  localparam logic [2:0] S_RD_P    = 3'd6;
  localparam logic [2:0] S_FIN     = 3'd7;

  function automatic logic [31:0] reg_addr(
    input logic [31:0] base,
    input logic [31:0] ofs
  );
    return base + ofs;
  endfunction

endpackage

// File: rtl/exponent_axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the exponent master sequencer
// and the exponent register slave.
interface exponent_axi4_lite_master_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, rready,
    output awready, wready, bvalid, bresp,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4lite_master_xact.sv
// Single-beat AXI4-Lite engine: one write (AW+W, then B) or one read
// (AR, then R) per request; every bus output comes from a flop.
module axi4lite_master_xact (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [1:0]  resp_o,
  output logic [31:0] rdata_o,
  exponent_axi4_lite_master_if.master m
);

  logic        awvalid_q, wvalid_q, bready_q;
  logic        arvalid_q, rready_q, wr_q, ack_q;
  logic [31:0] awaddr_q, wdata_q, araddr_q, rdata_q;
  logic [1:0]  resp_q;
  logic        aw_left, w_left;

  assign aw_left = awvalid_q && !m.awready;
  assign w_left  = wvalid_q && !m.wready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wr_q      <= 1'b0;
      ack_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      if (awvalid_q && m.awready) awvalid_q <= 1'b0;
      if (wvalid_q && m.wready) wvalid_q <= 1'b0;
      // B is only accepted once both address and data beats are gone
      if (wr_q && !bready_q && !aw_left && !w_left)
        bready_q <= 1'b1;
      if (bready_q && m.bvalid) begin
        bready_q <= 1'b0;
        wr_q     <= 1'b0;
        ack_q    <= 1'b1;
        resp_q   <= m.bresp;
      end
      if (arvalid_q && m.arready) begin
        arvalid_q <= 1'b0;
        rready_q  <= 1'b1;
      end
      if (rready_q && m.rvalid) begin
        rready_q <= 1'b0;
        ack_q    <= 1'b1;
        resp_q   <= m.rresp;
        rdata_q  <= m.rdata;
      end
      if (req_i && we_i) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awaddr_q  <= addr_i;
        wdata_q   <= wdata_i;
        wr_q      <= 1'b1;
      end else if (req_i) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr_i;
      end
    end
  end

  assign m.awaddr  = awaddr_q;
  assign m.awvalid = awvalid_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = 4'hF;
  assign m.wvalid  = wvalid_q;
  assign m.bready  = bready_q;
  assign m.araddr  = araddr_q;
  assign m.arvalid = arvalid_q;
  assign m.rready  = rready_q;

  assign ack_o   = ack_q;
  assign resp_o  = resp_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/exponent_axi4_lite_master.sv
// Sequencer for the exponent slave: writes X, A, START, polls DONE
// with a programmable gap, then reads P and reports it with o_done.
module exponent_axi4_lite_master
  import exponent_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h7c800000,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned POLL_MAX  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_X,
  input  logic [3:0]  i_A,
  output logic        o_busy,
  output logic        o_done,
  output logic [14:0] o_P,
  output logic        o_error,
  exponent_axi4_lite_master_if.master m_axi
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic [7:0] CNT_MAX  = 8'(POLL_MAX);

  logic [2:0]  state_q, state_d;
  logic        issued_q, issued_d;
  logic [3:0]  x_q, x_d, a_q, a_d;
  logic [7:0]  cnt_q, cnt_d, gap_q, gap_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        err_q, err_d;
  logic [14:0] p_q, p_d;

  logic        req, we, ack, bad;
  logic [31:0] ofs, wdata, rdata;
  logic [1:0]  resp;
  logic        unused_rdata;

  assign bad = resp != RESP_OKAY;
  assign unused_rdata = ^rdata[31:15];
  assign req = !issued_q && (state_q inside
    {S_WR_X, S_WR_A, S_WR_GO, S_RD_DONE, S_RD_P});

  always_comb begin
    we    = 1'b1;
    ofs   = OFS_X;
    wdata = {28'b0, x_q};
    unique case (state_q)
      S_WR_A: begin
        ofs   = OFS_A;
        wdata = {28'b0, a_q};
      end
      S_WR_GO: begin
        ofs   = OFS_START;
        wdata = 32'h1;
      end
      S_RD_DONE: begin
        we  = 1'b0;
        ofs = OFS_DONE;
      end
      S_RD_P: begin
        we  = 1'b0;
        ofs = OFS_P;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q | req;
    x_d      = x_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    p_d      = p_q;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_WR_X;
        x_d     = i_X;
        a_d     = i_A;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      S_WR_X:  if (ack) state_d = S_WR_A;
      S_WR_A:  if (ack) state_d = S_WR_GO;
      S_WR_GO: if (ack) state_d = S_RD_DONE;
      S_RD_DONE: if (ack) begin
        if (rdata[0]) begin
          state_d = S_RD_P;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == CNT_MAX) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end else if (POLL_GAP == 0) begin
            state_d = S_RD_DONE;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_RD_DONE;
        else gap_d = gap_q + 8'd1;
      end
      S_RD_P: if (ack) begin
        state_d = S_FIN;
        if (!bad) p_d = rdata[14:0];
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // an error response aborts the sequence without further traffic
    if (ack) begin
      issued_d = 1'b0;
      if (bad) begin
        state_d = S_FIN;
        err_d   = 1'b1;
      end
    end
    if (state_d == S_FIN && state_q != S_FIN) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      issued_q <= 1'b0;
      x_q      <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      x_q      <= x_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      p_q      <= p_d;
    end
  end

  axi4lite_master_xact u_xact (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (reg_addr(BASE_ADDR, ofs)),
    .wdata_i (wdata),
    .ack_o   (ack),
    .resp_o  (resp),
    .rdata_o (rdata),
    .m       (m_axi)
  );

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_P     = p_q;
  assign o_error = err_q;

endmodule
